aludec_mdu: RTL
===============

// Module: aludec_mdu
// PURPOSE
// - Next-generation ALU decoder: keeps the 3-bit alucontrol decode for the single-cycle ALU,
//   adds an iterative multiply/divide unit (MDU) with HI/LO registers for R-type mult/div/mf/mt.
// - Sits in the execute stage beside the ALU; mdu_stall holds the datapath during multi-cycle ops.
// PARAMETERS
// - WIDTH  32  operand/HI/LO width; iteration counter is $clog2(WIDTH) bits.
// PORTS
// - clk         in   1      single clock, all state on rising edge
// - reset       in   1      synchronous, active-high
// - valid       in   1      instruction in execute is live (0 = bubble/flush)
// - funct       in   6      R-type function field
// - aluop       in   2      00 add, 01 sub, 10 R-type (decode funct), 11 or (ori)
// - srca        in   WIDTH  rs operand
// - srcb        in   WIDTH  rt operand
// - alucontrol  out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
// - illegal     out  1      aluop=10 with undecoded funct (and valid)
// - mdu_stall   out  1      hold the execute instruction this cycle
// - mdu_result  out  WIDTH  HI for mfhi, LO for mflo, else 0
// BEHAVIOUR
// - Decode is combinational. aluop 00/01/11 -> 010/110/001. aluop 10: 100000 add->010,
//   100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111; MDU functs -> 010.
//   Other funct -> 010 and illegal=1. alucontrol is never X.
// - MDU functs: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi,
//   010001 mthi, 010010 mflo, 010011 mtlo. MDU acts only when valid && aluop==10.
// - FSM IDLE/RUN/DONE. Reset -> IDLE, hi=lo=0, counter=0, mdu_stall=0 (also mid-RUN).
// - IDLE + mult/div: latch operands, cnt=WIDTH-1, ->RUN; mdu_stall=1 in that cycle.
// - RUN: one radix-2 step per cycle; mdu_stall=1. After the cnt==0 step, write HI/LO and go to
//   DONE. The accept cycle plus WIDTH RUN cycles give WIDTH+1 stall cycles.
// - DONE: mdu_stall=0 and the instruction retires; no new start; ->IDLE next cycle.
// - Flush: valid=0 in RUN -> abort to IDLE, HI/LO unchanged, stall drops in that same cycle.
// - mfhi/mflo in IDLE: no stall, mdu_result is combinational from HI/LO. In RUN: stall.
// - mthi/mtlo in IDLE: write srca to HI/LO at the edge, no stall. In RUN: stall, no write.
// - mult: {HI,LO} = signed srca*srcb (2*WIDTH). multu: unsigned.
// - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign. divu: unsigned.
// - Divide by zero: LO=all ones, HI=srca. Signed MIN/-1: LO=MIN, HI=0. Same latency as normal.
// - Signed ops work on magnitudes; signs are fixed up in the final write. No extra cycle.
// CONFIGURATION
// - MDU_DIV_EN defined: divider datapath built; div/divu behave as above.
// - MDU_DIV_EN undefined: no divider logic; div/divu decode as illegal=1 with alucontrol=010.
//   They do not stall and leave HI/LO unchanged. mult/mf/mt are unaffected.
// TESTING
// - Decode sweep: all aluop values and every listed funct, plus funct 111111 -> table values;
//   illegal only for 111111 with aluop=10.
// - mult: srca=-3, srcb=7 (WIDTH=32) -> stall for exactly 33 cycles, then HI=FFFFFFFF,
//   LO=FFFFFFEB; mflo next gives mdu_result=FFFFFFEB.
// - div: srca=-7, srcb=2 -> LO=FFFFFFFD, HI=FFFFFFFF. divu 7/0 -> LO=FFFFFFFF, HI=7.
//   div 80000000/FFFFFFFF -> LO=80000000, HI=0.
// - Flush and reset: valid=0 at RUN cycle 5 -> IDLE, HI/LO keep prior values.
//   reset at RUN cycle 10 -> HI=LO=0, stall=0 in the next cycle.
// - Back-to-back: mult, then mfhi in the cycle after DONE -> mfhi sees the new HI with no stall.
//   mthi 0x1234 then mfhi -> mdu_result=0x1234.
// - WIDTH=8 build: multu FF*FF -> HI=FE, LO=01 after 9 stall cycles.
//   With MDU_DIV_EN undefined: div -> illegal=1, no stall.

Source files
------------

// File: rtl/aludec_mdu.sv
// aludec_mdu: ALU control decode plus an iterative radix-2 multiply/divide unit with HI/LO.
// Defining MDU_DIV_EN builds the divider; otherwise div/divu decode as illegal.
module aludec_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic             mdu_stall,
    output logic [WIDTH-1:0] mdu_result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo, acc, q, b, acc_n, q_n, mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, mres;
    logic               op_div, neg_q, neg_r, sa, sb;
    logic               mdu_act, is_mult, is_div, is_mf, is_mt, is_alu, start;
    logic [2:0]         rt_ctl;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]     rsh, diff;
`endif

    always_comb begin
        mdu_act = valid && aluop == 2'b10;
        is_mult = funct[5:1] == 5'b01100;
`ifdef MDU_DIV_EN
        is_div = funct[5:1] == 5'b01101;
`else
        is_div = 1'b0;
`endif
        is_mf = funct == 6'b010000 || funct == 6'b010010;
        is_mt = funct == 6'b010001 || funct == 6'b010011;
        is_alu = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rt_ctl = funct == 6'b100010 ? 3'b110 : funct == 6'b100100 ? 3'b000 :
                 funct == 6'b100101 ? 3'b001 : funct == 6'b101010 ? 3'b111 : 3'b010;
        alucontrol = aluop == 2'b01 ? 3'b110 : aluop == 2'b11 ? 3'b001 :
                     aluop == 2'b10 ? rt_ctl : 3'b010;
        illegal = mdu_act && !(is_alu || is_mult || is_div || is_mf || is_mt);
        start = state == IDLE && mdu_act && (is_mult || is_div);
        mdu_stall = !reset && (start || (state == RUN && valid));
        mdu_result = mdu_act && funct == 6'b010000 ? hi :
                     mdu_act && funct == 6'b010010 ? lo : '0;
        // funct[0] clear selects the signed variant of both mult and div
        sa = !funct[0] && srca[WIDTH-1];
        sb = !funct[0] && srcb[WIDTH-1];
        mag_a = sa ? -srca : srca;
        mag_b = sb ? -srcb : srcb;
    end

    always_comb begin
        sum = {1'b0, acc} + {1'b0, {WIDTH{q[0]}} & b};
`ifdef MDU_DIV_EN
        rsh = {acc, q[WIDTH-1]};
        diff = rsh - {1'b0, b};
        acc_n = op_div ? (diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        q_n = op_div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
`else
        acc_n = sum[WIDTH:1];
        q_n = {sum[0], q[WIDTH-1:1]};
`endif
        prod = {acc_n, q_n};
        mres = neg_q ? -prod : prod;
        quo = neg_q ? -q_n : q_n;
        rem = neg_r ? -acc_n : acc_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            acc <= '0;
            q <= '0;
            b <= '0;
            op_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        q <= mag_a;
                        b <= mag_b;
                        op_div <= is_div;
                        // a zero divisor keeps the all-ones quotient unsigned
                        neg_q <= (sa ^ sb) && !(is_div && srcb == '0);
                        neg_r <= sa;
                        cnt <= CNT_INIT;
                        state <= RUN;
                    end else if (mdu_act && is_mt) begin
                        if (funct[1]) lo <= srca;
                        else hi <= srca;
                    end
                end
                RUN: begin
                    if (!valid) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_n;
                        q <= q_n;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            hi <= op_div ? rem : mres[2*WIDTH-1:WIDTH];
                            lo <= op_div ? quo : mres[WIDTH-1:0];
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
